mem_rw_helper_mp: RTL and testbench

Parametrised simulation-only memory model for the difftest/GCPT harness. It serves NUM_RD read ports and one write port from the shared DPI-C RAM image (init_ram / ram_read_data / ram_write_data). Compared with the single-port 64-bit helper it adds:
- configurable data width (lanes of 64 bits) and read latency;
- a base-address window with out-of-range detection;
- deterministic read-before-write ordering;
- request counters.

---
 rtl/mem_helper_pkg.sv | 46 ++++
 rtl/mem_rd_pipe.sv | 49 ++++
 rtl/mem_rw_helper_mp.sv | 114 +++++++++++
 tb/tb_mem_rw_helper_mp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_helper_pkg.sv
// Shared RAM image for the memory helpers, plus the helpers' common constants.
// The image is a sparse 64-bit-word store behind the init_ram / ram_read_data / ram_write_data calls.
package mem_helper_pkg;

  localparam int LANE_W = 64;
`ifdef GCPT_IMAGE
  localparam logic [63:0] DEF_RAM_SIZE = 64'h2_0000_0000;
`else
  localparam logic [63:0] DEF_RAM_SIZE = 64'h0_8000_0000;
`endif

  // Sparse image keyed by 64-bit word index; unwritten words read as zero.
  logic [63:0] ram_img [bit [63:0]];
  logic [63:0] ram_size  = '0;
  bit          ram_ready = 1'b0;
  int unsigned rd_calls  = 0;
  int unsigned wr_calls  = 0;

  // Idempotent so a re-init after reset never wipes the image.
  function automatic void init_ram(input logic [63:0] size);
    if (!ram_ready) begin
      ram_size  = size;
      ram_ready = 1'b1;
    end
  endfunction

  function automatic logic [63:0] ram_read_data(input logic [63:0] idx);
    rd_calls++;
    return ram_img.exists(idx) ? ram_img[idx] : 64'h0;
  endfunction

  function automatic void ram_write_data(input logic [63:0] idx, input logic [63:0] mask,
                                         input logic [63:0] data);
    logic [63:0] old;
    old = ram_img.exists(idx) ? ram_img[idx] : 64'h0;
    ram_img[idx] = (old & ~mask) | (data & mask);
    wr_calls++;
  endfunction

  function automatic logic [LANE_W-1:0] strb_to_mask(input logic [LANE_W/8-1:0] strb);
    logic [LANE_W-1:0] mask;
    for (int i = 0; i < LANE_W/8; i++) mask[i*8 +: 8] = {8{strb[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Per-port read delay line carrying {valid, oob, data}; DEPTH=0 is a pass-through.
module mem_rd_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_oob,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_oob,
  output logic [DATA_WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_oob   = in_oob;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0]                 vld_pipe;
      logic [DEPTH-1:0]                 oob_pipe;
      logic [DEPTH-1:0][DATA_WIDTH-1:0] dat_pipe;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          vld_pipe <= '0;
          oob_pipe <= '0;
          dat_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_valid;
          oob_pipe[0] <= in_oob;
          dat_pipe[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            oob_pipe[i] <= oob_pipe[i-1];
            dat_pipe[i] <= dat_pipe[i-1];
          end
        end
      end

      assign out_valid = vld_pipe[DEPTH-1];
      assign out_oob   = oob_pipe[DEPTH-1];
      assign out_data  = dat_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mem_rw_helper_mp.sv
// Multi-read-port / single-write-port front end onto the shared RAM image.
// Reads are issued before the write inside one always block, so same-edge read/write sees old data.
module mem_rw_helper_mp
  import mem_helper_pkg::*;
#(
  parameter int          NUM_RD     = 2,
  parameter int          DATA_WIDTH = 64,
  parameter int          RD_LATENCY = 1,
  parameter logic [63:0] RAM_SIZE   = DEF_RAM_SIZE,
  parameter logic [63:0] BASE_IDX   = '0,
  parameter bit          DO_INIT    = 1'b1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_RD-1:0]                   r_enable,
  input  logic [NUM_RD-1:0][63:0]             r_index,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]   r_data,
  output logic [NUM_RD-1:0]                   r_valid,
  output logic [NUM_RD-1:0]                   r_oob,
  input  logic                                w_enable,
  input  logic [63:0]                         w_index,
  input  logic [DATA_WIDTH-1:0]               w_data,
  input  logic [DATA_WIDTH/8-1:0]             w_strb,
  output logic                                w_oob,
  output logic [31:0]                         rd_count,
  output logic [31:0]                         wr_count
);

  localparam int          NLANE  = DATA_WIDTH / LANE_W;
  localparam int          CW     = $clog2(NUM_RD + 1);
  localparam logic [63:0] BEAT_B = 64'(NLANE * 8);
  // off*BEAT_B < RAM_SIZE rewritten as off < ceil(RAM_SIZE/BEAT_B) so huge offsets cannot wrap back in.
  localparam logic [63:0] BEATS  = (RAM_SIZE + BEAT_B - 64'd1) / BEAT_B;

  function automatic logic [63:0] word_idx(input logic [63:0] idx, input int lane);
    return (idx - BASE_IDX) * 64'(NLANE) + 64'(lane);
  endfunction

  function automatic logic in_range(input logic [63:0] idx);
    return (idx - BASE_IDX) < BEATS;
  endfunction

  logic [NUM_RD-1:0]                 acc_valid;
  logic [NUM_RD-1:0]                 acc_oob;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] acc_data;
  logic                              init_done;
  logic [CW-1:0]                     rd_acc;

  always_comb begin
    rd_acc = '0;
    for (int p = 0; p < NUM_RD; p++) rd_acc += CW'(enable && r_enable[p]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_valid <= '0;
      acc_oob   <= '0;
      acc_data  <= '0;
      init_done <= 1'b0;
      w_oob     <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      if (DO_INIT && !init_done) begin
        init_ram(RAM_SIZE);
        init_done <= 1'b1;
      end

      acc_valid <= '0;
      acc_oob   <= '0;
      acc_data  <= '0;
      for (int p = 0; p < NUM_RD; p++) begin
        if (enable && r_enable[p]) begin
          acc_valid[p] <= 1'b1;
          if (in_range(r_index[p])) begin
            for (int l = 0; l < NLANE; l++)
              acc_data[p][l*LANE_W +: LANE_W] <= ram_read_data(word_idx(r_index[p], l));
          end else begin
            acc_oob[p] <= 1'b1;
          end
        end
      end

      w_oob <= 1'b0;
      if (enable && w_enable) begin
        if (in_range(w_index)) begin
          for (int l = 0; l < NLANE; l++) begin
            if (strb_to_mask(w_strb[l*8 +: 8]) != '0)
              ram_write_data(word_idx(w_index, l), strb_to_mask(w_strb[l*8 +: 8]),
                             w_data[l*LANE_W +: LANE_W]);
          end
        end else begin
          w_oob <= 1'b1;
        end
      end

      rd_count <= rd_count + 32'(rd_acc);
      wr_count <= wr_count + 32'(enable && w_enable);
    end
  end

  mem_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(RD_LATENCY - 1)) u_rd_pipe [NUM_RD-1:0] (
    .clock    (clock),
    .reset    (reset),
    .in_valid (acc_valid),
    .in_oob   (acc_oob),
    .in_data  (acc_data),
    .out_valid(r_valid),
    .out_oob  (r_oob),
    .out_data (r_data)
  );

endmodule

// File: tb/tb_mem_rw_helper_mp.sv
// Directed + random bench for mem_rw_helper_mp against a beat-level reference model.
module tb_mem_rw_helper_mp;
  localparam int          NP   = 2;
  localparam int          DW   = 128;
  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h1000_0000;
  localparam logic [63:0] NBEAT = 64'h0800_0000;  // 2 GiB / 16-byte beats

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       enable;
  logic [NP-1:0]              r_enable;
  logic [NP-1:0][63:0]        r_index;
  logic [NP-1:0][DW-1:0]      r_data;
  logic [NP-1:0]              r_valid;
  logic [NP-1:0]              r_oob;
  logic                       w_enable;
  logic [63:0]                w_index;
  logic [DW-1:0]              w_data;
  logic [DW/8-1:0]            w_strb;
  logic                       w_oob;
  logic [31:0]                rd_count;
  logic [31:0]                wr_count;

  mem_rw_helper_mp #(.NUM_RD(NP), .DATA_WIDTH(DW), .RD_LATENCY(LAT), .BASE_IDX(BASE)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .r_enable(r_enable), .r_index(r_index), .r_data(r_data), .r_valid(r_valid), .r_oob(r_oob),
    .w_enable(w_enable), .w_index(w_index), .w_data(w_data), .w_strb(w_strb), .w_oob(w_oob),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: beat-addressed memory, per-port result history, counters.
  logic [DW-1:0] mem [bit [63:0]];
  logic          hv [NP][LAT];
  logic          ho [NP][LAT];
  logic [DW-1:0] hd [NP][LAT];
  logic          m_woob;
  logic [31:0]   m_rd, m_wr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < LAT; k++) begin hv[p][k] = 0; ho[p][k] = 0; hd[p][k] = '0; end
    m_woob = 0; m_rd = 0; m_wr = 0;
  endtask

  function automatic logic [DW-1:0] peek(input logic [63:0] off);
    return mem.exists(off) ? mem[off] : '0;
  endfunction

  task automatic model_edge();
    logic          nv [NP];
    logic          no [NP];
    logic [DW-1:0] nd [NP];
    logic [DW-1:0] mask;
    logic [63:0]   off;
    if (reset) begin model_clear(); return; end
    for (int p = 0; p < NP; p++) begin
      nv[p] = enable && r_enable[p]; no[p] = 0; nd[p] = '0;
      if (nv[p]) begin
        m_rd++;
        off = r_index[p] - BASE;
        if (off < NBEAT) nd[p] = peek(off); else no[p] = 1;
      end
    end
    m_woob = 0;
    if (enable && w_enable) begin
      m_wr++;
      off = w_index - BASE;
      if (off < NBEAT) begin
        mask = '0;
        for (int b = 0; b < DW/8; b++) if (w_strb[b]) mask[b*8 +: 8] = 8'hFF;
        mem[off] = (peek(off) & ~mask) | (w_data & mask);
      end else m_woob = 1;
    end
    for (int p = 0; p < NP; p++) begin
      for (int k = LAT-1; k > 0; k--) begin hv[p][k] = hv[p][k-1]; ho[p][k] = ho[p][k-1]; hd[p][k] = hd[p][k-1]; end
      hv[p][0] = nv[p]; ho[p][0] = no[p]; hd[p][0] = nd[p];
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s.valid%0d", tag, p), DW'(r_valid[p]), DW'(hv[p][LAT-1]));
      if (hv[p][LAT-1]) begin
        chk($sformatf("%s.oob%0d", tag, p), DW'(r_oob[p]), DW'(ho[p][LAT-1]));
        chk($sformatf("%s.data%0d", tag, p), r_data[p], hd[p][LAT-1]);
      end
    end
    chk({tag, ".w_oob"}, DW'(w_oob), DW'(m_woob));
    chk({tag, ".rd_count"}, DW'(rd_count), DW'(m_rd));
    chk({tag, ".wr_count"}, DW'(wr_count), DW'(m_wr));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic idle();
    r_enable = '0; w_enable = 0;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int unsigned c0;
    reset = 1; enable = 1; r_enable = '0; r_index = '0;
    w_enable = 0; w_index = '0; w_data = '0; w_strb = '0;
    model_clear();
    step("rst"); step("rst");
    chk("rst.r_data0", r_data[0], '0);
    chk("rst.r_oob", DW'(r_oob), '0);
    reset = 0;
    step("idle");

    // write then read back with full strobes
    w_enable = 1; w_index = BASE; w_strb = '1;
    w_data = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
    step("wr0");
    idle(); r_enable[0] = 1; r_index[0] = BASE;
    step("rd0_acc");
    idle();
    step("rd0_out");
    chk("t1.rd_count", DW'(rd_count), DW'(1));
    chk("t1.wr_count", DW'(wr_count), DW'(1));

    // partial strobe: only lane 0 upper half, one lane write call
    w_enable = 1; w_index = BASE + 1; w_strb = '1; w_data = '0;
    step("pre0");
    c0 = mem_helper_pkg::wr_calls;
    w_strb = 16'h00F0; w_data = rnd128();
    step("strb");
    chk("strb.lane_calls", DW'(mem_helper_pkg::wr_calls - c0), DW'(1));
    idle(); r_enable[1] = 1; r_index[1] = BASE + 1;
    step("strb_rd"); idle(); step("strb_out");

    // same-edge read/write returns old data
    w_enable = 1; w_index = BASE + 2; w_strb = '1; w_data = 128'h11;
    step("old");
    w_data = 128'h22; r_enable[1] = 1; r_index[1] = BASE + 2;
    step("rw_same");
    w_enable = 0;
    step("rw_next");
    chk("rw.old_data", r_data[1], 128'h11);
    idle(); step("rw_new");
    chk("rw.new_data", r_data[1], 128'h22);

    // out-of-range read below base, write beyond end
    c0 = mem_helper_pkg::rd_calls;
    r_enable[0] = 1; r_index[0] = BASE - 1;
    step("oob_rd");
    chk("oob_rd.calls", DW'(mem_helper_pkg::rd_calls - c0), '0);
    idle(); c0 = mem_helper_pkg::wr_calls;
    w_enable = 1; w_index = BASE + NBEAT; w_strb = '1; w_data = rnd128();
    step("oob_wr");
    chk("oob_wr.pulse", DW'(w_oob), DW'(1));
    chk("oob_wr.calls", DW'(mem_helper_pkg::wr_calls - c0), '0);
    idle(); step("oob_wr_end");

    // streaming reads, then asynchronous reset mid-stream
    for (int i = 0; i < 8; i++) begin
      r_enable = '1;
      r_index[0] = BASE + 64'($urandom_range(0, 7));
      r_index[1] = BASE + 64'($urandom_range(0, 7));
      step("stream");
    end
    reset = 1;
    #1;
    model_clear();
    chk("arst.r_valid", DW'(r_valid), '0);
    chk("arst.rd_count", DW'(rd_count), '0);
    step("arst_hold");
    reset = 0; idle();
    step("post_rst"); step("post_rst");
    r_enable[0] = 1; r_index[0] = BASE;
    step("keep_rd"); idle(); step("keep_out");
    chk("keep.image", r_data[0], 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555);

    // enable low: in-flight reads drain, nothing accepted
    r_enable = '1; r_index[0] = BASE + 2; r_index[1] = BASE + 1;
    step("en_pre");
    enable = 0; w_enable = 1; w_index = BASE; w_data = rnd128(); w_strb = '1;
    for (int i = 0; i < 3; i++) step("en_low");
    enable = 1; idle(); step("en_back");

    // random traffic
    for (int i = 0; i < 80; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < NP; p++) begin
        r_enable[p] = $urandom_range(0, 1);
        case ($urandom_range(0, 9))
          0:       r_index[p] = BASE - 64'($urandom_range(1, 3));
          1:       r_index[p] = BASE + NBEAT + 64'($urandom_range(0, 3));
          default: r_index[p] = BASE + 64'($urandom_range(0, 7));
        endcase
      end
      w_enable = $urandom_range(0, 1);
      w_index  = ($urandom_range(0, 9) == 0) ? BASE + NBEAT : BASE + 64'($urandom_range(0, 7));
      w_data   = rnd128();
      w_strb   = 16'($urandom);
      step("rand");
    end
    enable = 1; idle();
    step("drain"); step("drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
